// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch-stage types and constants
package fetch_pkg;

  localparam int XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_RESET = 32'h8000_0000;

endpackage

// File: rtl/fetch_ifq_mem.sv
// rtl/fetch_ifq_mem.sv - instruction queue entry array, 1 write port, 1 async read port
module fetch_ifq_mem
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_idx,
  input  fetch_entry_t     wr_data,
  input  logic [PTR_W-1:0] rd_idx,
  output fetch_entry_t     rd_data
);

  // Data array is deliberately not reset; the pointers decide what is reachable.
  fetch_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/fetch_inst_queue.sv
// rtl/fetch_inst_queue.sv - IFU->IDU decoupling FIFO; IFQ_BYPASS_EN enables empty-queue bypass
module fetch_inst_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = fetch_pkg::XLEN,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_inst,
  output logic [PTR_W:0]  count
);

  logic [PTR_W:0] wr_ptr, rd_ptr, cnt_q;
  logic [PTR_W:0] wr_ptr_nxt, rd_ptr_nxt;
  logic           empty, full, push, pop, bypass;
  fetch_entry_t   head, in_entry, out_entry;

  assign in_entry = '{pc: in_pc, inst: in_inst};

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]) && (wr_ptr[PTR_W] != rd_ptr[PTR_W]);

  // A full queue refuses pushes even when a pop frees a slot this cycle.
  assign in_ready = rst & ~full & ~flush;

`ifdef IFQ_BYPASS_EN
  assign bypass    = empty & in_valid & out_ready & in_ready;
  assign out_valid = rst & ~flush & (~empty | in_valid);
  assign out_entry = empty ? in_entry : head;
`else
  assign bypass    = 1'b0;
  assign out_valid = rst & ~flush & ~empty;
  assign out_entry = head;
`endif

  // A bypassed pair is consumed directly and never touches storage.
  assign push = in_valid & in_ready & ~bypass;
  assign pop  = out_valid & out_ready & ~empty;

  assign wr_ptr_nxt = wr_ptr + {{PTR_W{1'b0}}, push};
  assign rd_ptr_nxt = rd_ptr + {{PTR_W{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      cnt_q  <= wr_ptr_nxt - rd_ptr_nxt;
    end
  end

  assign count = cnt_q;

  always_comb begin
    out_pc   = '0;
    out_inst = '0;
    if (out_valid) begin
      out_pc   = out_entry.pc;
      out_inst = out_entry.inst;
    end
  end

  fetch_ifq_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_idx  (wr_ptr[PTR_W-1:0]),
    .wr_data (in_entry),
    .rd_idx  (rd_ptr[PTR_W-1:0]),
    .rd_data (head)
  );

endmodule

// File: tb/tb_fetch_inst_queue.sv
// tb/tb_fetch_inst_queue.sv - scoreboard bench for fetch_inst_queue, either IFQ_BYPASS_EN build
module tb_fetch_inst_queue;

  localparam int DEPTH = 4;
`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_inst = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [2:0]  count;

  int checks = 0;
  int failures = 0;
  int mcount = 0;
  logic [63:0] exp_q [$];

  fetch_inst_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every completed output handshake must match the oldest accepted pair.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL out_unexpected actual_pc=%0h required=none at %0t", out_pc, $time);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("out_pc", out_pc, e[63:32]);
        check("out_inst", out_inst, e[31:0]);
      end
    end
  end

  // One cycle of stimulus; the occupancy model is a plain counter of buffered pairs.
  task automatic step(input bit iv, input logic [31:0] pc, input logic [31:0] inst,
                      input bit ordy, input bit fl);
    bit acc, byp, exp_ov, deq;
    in_valid = iv; in_pc = pc; in_inst = inst; out_ready = ordy; flush = fl;
    acc    = iv && !fl && (mcount < DEPTH);
    byp    = BYP && acc && ordy && (mcount == 0);
    exp_ov = !fl && ((mcount > 0) || (BYP && iv && mcount == 0));
    deq    = exp_ov && ordy;
    if (fl) exp_q.delete();
    if (acc) exp_q.push_back({pc, inst});
    @(negedge clk);
    check("in_ready", in_ready, !fl && (mcount < DEPTH));
    check("out_valid", out_valid, exp_ov);
    check("count", count, mcount);
    if (!exp_ov) check("out_pc_idle", out_pc, 32'h0);
    if (fl) mcount = 0;
    else mcount = mcount + int'(acc && !byp) - int'(deq && !byp);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_count", count, 3'd0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    step(0, 32'h0, 32'h0, 0, 0);

    for (int k = 0; k < 4; k++) step(1, 32'h8000_0000 + 4 * k, 32'h13 + k, 0, 0);
    step(1, 32'h8000_0010, 32'h17, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 32'h0, 32'h0, 1, 0);
    step(0, 32'h0, 32'h0, 1, 0);

    step(1, 32'h8000_0020, 32'h20, 0, 0);
    step(1, 32'h8000_0024, 32'h21, 0, 0);
    for (int k = 0; k < 10; k++) step(1, 32'h8000_0028 + 4 * k, 32'h22 + k, 1, 0);

    step(1, 32'h8000_0050, 32'h50, 0, 0);
    step(1, 32'h8000_0054, 32'h51, 1, 1);
    step(1, 32'h8000_0100, 32'h100, 0, 0);
    step(0, 32'h0, 32'h0, 1, 0);

    step(1, 32'h8000_0200, 32'h200, 1, 0);
    step(0, 32'h0, 32'h0, 1, 0);

    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 3) != 0, 32'h8000_1000 + 4 * i, $urandom,
           $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0);

    for (int k = 0; k < 6; k++) step(0, 32'h0, 32'h0, 1, 0);
    check("drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
